// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: X = A + B*W, Y = A - B*W, four register stages,
// one butterfly per clock, optional divide-by-2 and a sticky clip flag.
module fft_butterfly #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [TW_W-1:0]   tw_re,
    input  logic signed [TW_W-1:0]   tw_im,
    input  logic                     scale,
    input  logic                     sat_clr,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] x_re,
    output logic signed [DATA_W-1:0] x_im,
    output logic signed [DATA_W-1:0] y_re,
    output logic signed [DATA_W-1:0] y_im,
    output logic                     sat,
    output logic                     busy
);

    localparam int PW  = DATA_W + TW_W;
    localparam int SW  = PW + 1;
    localparam int TW2 = DATA_W + 2;
    localparam int XW  = DATA_W + 3;

    localparam logic signed [SW-1:0] RND  = SW'(longint'(1) << (TW_W - 2));
    localparam logic signed [XW-1:0] MAXV = XW'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [XW-1:0] MINV = XW'(-(longint'(1) << (DATA_W - 1)));

    function automatic logic signed [TW2-1:0] round_trunc(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        r = s + RND;
        r = r >>> (TW_W - 1);
        return r[TW2-1:0];
    endfunction

    function automatic logic signed [XW-1:0] scale_fn(input logic signed [XW-1:0] v,
                                                      input logic sc);
        logic signed [XW-1:0] r;
        r = sc ? (v >>> 1) : v;
        return r;
    endfunction

    function automatic logic clips(input logic signed [XW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] r;
        if (v > MAXV)      r = MAXV;
        else if (v < MINV) r = MINV;
        else               r = v;
        return r[DATA_W-1:0];
    endfunction

    logic                     vld_p0, vld_p1, vld_p2;
    logic signed [DATA_W-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
    logic signed [TW_W-1:0]   tw_re_p0, tw_im_p0;
    logic                     scale_p0, scale_p1, scale_p2;
    logic signed [DATA_W-1:0] a_re_p1, a_im_p1, a_re_p2, a_im_p2;
    logic signed [PW-1:0]     p_rr_p1, p_ii_p1, p_ri_p1, p_ir_p1;
    logic signed [TW2-1:0]    t_re_p2, t_im_p2;

    logic signed [SW-1:0]     s_re, s_im;
    logic signed [XW-1:0]     xs_re, xs_im, ys_re, ys_im;
    logic                     clip_p2;

    always_comb begin
        s_re    = SW'(p_rr_p1) - SW'(p_ii_p1);
        s_im    = SW'(p_ri_p1) + SW'(p_ir_p1);
        xs_re   = scale_fn(XW'(a_re_p2) + XW'(t_re_p2), scale_p2);
        xs_im   = scale_fn(XW'(a_im_p2) + XW'(t_im_p2), scale_p2);
        ys_re   = scale_fn(XW'(a_re_p2) - XW'(t_re_p2), scale_p2);
        ys_im   = scale_fn(XW'(a_im_p2) - XW'(t_im_p2), scale_p2);
        clip_p2 = vld_p2 && (clips(xs_re) || clips(xs_im) || clips(ys_re) || clips(ys_im));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            a_re_p0   <= '0;
            a_im_p0   <= '0;
            b_re_p0   <= '0;
            b_im_p0   <= '0;
            tw_re_p0  <= '0;
            tw_im_p0  <= '0;
            scale_p0  <= 1'b0;
            a_re_p1   <= '0;
            a_im_p1   <= '0;
            scale_p1  <= 1'b0;
            p_rr_p1   <= '0;
            p_ii_p1   <= '0;
            p_ri_p1   <= '0;
            p_ir_p1   <= '0;
            a_re_p2   <= '0;
            a_im_p2   <= '0;
            scale_p2  <= 1'b0;
            t_re_p2   <= '0;
            t_im_p2   <= '0;
            x_re      <= '0;
            x_im      <= '0;
            y_re      <= '0;
            y_im      <= '0;
        end else begin
            // S1: capture operands
            vld_p0   <= in_valid;
            a_re_p0  <= a_re;
            a_im_p0  <= a_im;
            b_re_p0  <= b_re;
            b_im_p0  <= b_im;
            tw_re_p0 <= tw_re;
            tw_im_p0 <= tw_im;
            scale_p0 <= scale;
            // S2: partial products
            vld_p1   <= vld_p0;
            a_re_p1  <= a_re_p0;
            a_im_p1  <= a_im_p0;
            scale_p1 <= scale_p0;
            p_rr_p1  <= PW'(b_re_p0) * PW'(tw_re_p0);
            p_ii_p1  <= PW'(b_im_p0) * PW'(tw_im_p0);
            p_ri_p1  <= PW'(b_re_p0) * PW'(tw_im_p0);
            p_ir_p1  <= PW'(b_im_p0) * PW'(tw_re_p0);
            // S3: complex product T = B*W, rounded back to data scale
            vld_p2   <= vld_p1;
            a_re_p2  <= a_re_p1;
            a_im_p2  <= a_im_p1;
            scale_p2 <= scale_p1;
            t_re_p2  <= round_trunc(s_re);
            t_im_p2  <= round_trunc(s_im);
            // S4: butterfly, scale, saturate; outputs hold across idle slots
            out_valid <= vld_p2;
            if (vld_p2) begin
                x_re <= sat_fn(xs_re);
                x_im <= sat_fn(xs_im);
                y_re <= sat_fn(ys_re);
                y_im <= sat_fn(ys_im);
            end
            if (clip_p2)      sat <= 1'b1;
            else if (sat_clr) sat <= 1'b0;
        end
    end

    assign busy = vld_p0 | vld_p1 | vld_p2 | out_valid;

endmodule

// File: tb/tb_fft_butterfly.sv
// Scoreboard bench for fft_butterfly: directed cases plus a random stream,
// each compared against a floor-division reference model.
module tb_fft_butterfly;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic signed [15:0] tw_re = '0, tw_im = '0;
    logic               scale = 1'b0;
    logic               sat_clr = 1'b0;
    logic               out_valid, sat, busy;
    logic signed [15:0] x_re, x_im, y_re, y_im;

    fft_butterfly #(.DATA_W(16), .TW_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .tw_re(tw_re), .tw_im(tw_im), .scale(scale), .sat_clr(sat_clr),
        .out_valid(out_valid), .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
        .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int xr, xi, yr, yi;
        bit clip;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc_cnt);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic int clamp(input longint v, inout bit c);
        if (v > 32767)  begin c = 1'b1; return 32767;  end
        if (v < -32768) begin c = 1'b1; return -32768; end
        return int'(v);
    endfunction

    // Reference: T = round_half_up(B*W / 2^15); X/Y = A +/- T, optional floor /2, clamp.
    function automatic exp_t model(input int ar, ai, br, bi, wr, wi, input bit sc);
        exp_t   e;
        longint tr, ti, xr, xi, yr, yi;
        bit     c = 1'b0;
        tr = fdiv(longint'(br) * wr - longint'(bi) * wi + 16384, 32768);
        ti = fdiv(longint'(br) * wi + longint'(bi) * wr + 16384, 32768);
        xr = ar + tr; xi = ai + ti; yr = ar - tr; yi = ai - ti;
        if (sc) begin
            xr = fdiv(xr, 2); xi = fdiv(xi, 2); yr = fdiv(yr, 2); yi = fdiv(yi, 2);
        end
        e.xr = clamp(xr, c); e.xi = clamp(xi, c);
        e.yr = clamp(yr, c); e.yi = clamp(yi, c);
        e.clip = c;
        e.cyc = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ar, ai, br, bi, wr, wi, input bit sc);
        exp_t e;
        a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
        tw_re = 16'(wr); tw_im = 16'(wi); scale = sc; in_valid = 1'b1;
        e = model(ar, ai, br, bi, wr, wi, sc);
        e.cyc = cyc_cnt + 4;
        q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int rnd();
        logic [15:0] u;
        u = 16'($urandom);
        return int'($signed(u));
    endfunction

    // Monitor: pop and compare whenever the DUT presents a result
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            exp_t e;
            n_out++;
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out: out_valid with empty scoreboard at cycle %0d", cyc_cnt);
            end else begin
                e = q.pop_front();
                check("latency", cyc_cnt, e.cyc);
                check("x_re", int'(x_re), e.xr);
                check("x_im", int'(x_im), e.xi);
                check("y_re", int'(y_re), e.yr);
                check("y_im", int'(y_im), e.yi);
                if (e.clip) check("sat_on_clip", int'(sat), 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int n_before;
        repeat (3) tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_x_re", int'(x_re), 0);
        rst_n = 1'b1;
        tick();

        // Single butterfly: busy for exactly four cycles
        check("idle_busy", int'(busy), 0);
        send(1000, 0, 500, 0, 32767, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("busy_in_flight", int'(busy), 1);
            if (i < 3) tick();
        end
        check("single_sat", int'(sat), 0);
        tick();
        check("busy_drained", int'(busy), 0);
        check("single_x_re", int'(x_re), 1500);
        check("single_y_re", int'(y_re), 500);
        check("single_x_im", int'(x_im), 0);

        send(1000, 0, 500, 0, 32767, 0, 1'b1);
        repeat (4) tick();
        check("scale_x_re", int'(x_re), 750);
        check("scale_y_re", int'(y_re), 250);

        send(0, 0, 100, 200, 0, -32768, 1'b0);
        repeat (4) tick();
        check("mj_x_re", int'(x_re), 200);
        check("mj_x_im", int'(x_im), -100);
        check("mj_y_re", int'(y_re), -200);
        check("mj_y_im", int'(y_im), 100);

        // Overflow, sticky flag, clear, and clear colliding with a new clip
        send(32767, 0, 32767, 0, 32767, 0, 1'b0);
        repeat (3) tick();
        check("ovf_sat", int'(sat), 1);
        check("ovf_x_re", int'(x_re), 32767);
        check("ovf_y_re", int'(y_re), 1);
        repeat (2) tick();
        check("sat_sticky", int'(sat), 1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_cleared", int'(sat), 0);
        send(32767, 0, 32767, 0, 32767, 0, 1'b0);
        repeat (2) tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_set_wins", int'(sat), 1);
        repeat (2) tick();

        // Back-to-back random stream
        n_before = n_out;
        for (int i = 0; i < 8; i++)
            send(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)));
        repeat (6) tick();
        check("stream_count", n_out - n_before, 8);

        // Reset with three butterflies in flight
        send(32767, 0, 32767, 0, 32767, 0, 1'b0);
        send(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 1'b0);
        send(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 1'b1);
        rst_n = 1'b0;
        q.delete();
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_sat", int'(sat), 0);
        n_before = n_out;
        repeat (6) tick();
        check("no_stale_out", n_out - n_before, 0);

        send(1000, 0, 500, 0, 32767, 0, 1'b0);
        repeat (2) tick();
        check("post_rst_not_early", int'(out_valid), 0);
        tick();
        check("post_rst_latency", int'(out_valid), 1);
        check("post_rst_x_re", int'(x_re), 1500);
        repeat (3) tick();
        check("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_butterfly.md
Name: fft_butterfly

Overview:
- Radix-2 decimation-in-time butterfly datapath for one FFT stage.
- Sits directly downstream of the coefficient mapper (c_mapper). Each cycle it takes one operand pair from stage RAM plus the twiddle selected by the mapper, and produces X = A + B·W and Y = A − B·W.
- Fully pipelined: one butterfly per clock, fixed latency, no backpressure.
- Per-stage scaling and a sticky saturation flag keep fixed-point growth under control.

Parameters:
- DATA_W, 16, signed width of the A/B inputs and X/Y outputs (two's complement).
- TW_W, 16, signed twiddle width, Q1.(TW_W−1) format; full scale is 2^(TW_W−1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands on this cycle are a valid butterfly.
- a_re, a_im  input  DATA_W each  operand A.
- b_re, b_im  input  DATA_W each  operand B.
- tw_re, tw_im  input  TW_W each  twiddle W from the coefficient mapper.
- scale  input  1  1 = divide both results by 2; sampled together with in_valid.
- sat_clr  input  1  clears the sticky saturation flag.
- out_valid  output  1  X/Y are valid this cycle.
- x_re, x_im  output  DATA_W each  result A + B·W.
- y_re, y_im  output  DATA_W each  result A − B·W.
- sat  output  1  sticky flag: a result was clipped.
- busy  output  1  at least one butterfly is in flight.

Behaviour:
- Reset: a synchronous rst_n low clears all pipeline valid bits, data registers, out_valid, sat and busy to 0. Reset asserted mid-operation discards in-flight butterflies, and no out_valid is produced for them.
- Pipeline: 4 register stages; latency is exactly 4 cycles from the in_valid edge to the matching out_valid. One new butterfly may be accepted every cycle. Valid bits shift unconditionally each cycle.
- S1: register A, B, W, scale and in_valid.
- S2: register the four signed products b_re·tw_re, b_im·tw_im, b_re·tw_im and b_im·tw_re. Each product is DATA_W+TW_W bits wide.
- S3 (complex product T = B·W):
  - t_re = b_re·tw_re − b_im·tw_im
  - t_im = b_re·tw_im + b_im·tw_re
  - Each sum is computed at DATA_W+TW_W+1 bits. Add 2^(TW_W−2) (round half up), then arithmetic shift right by TW_W−1.
  - Keep DATA_W+2 bits and register them. No saturation happens here.
- S4 (butterfly):
  - x = a + t and y = a − t, computed at DATA_W+3 bits.
  - If scale = 1, arithmetic shift right by 1 (truncate toward −∞).
  - Each component is then saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and registered onto the outputs.
- sat:
  - Set in the cycle a valid S4 result clips any of its four components.
  - Held until sat_clr = 1, which clears it.
  - If sat_clr and a new clip occur in the same cycle, set wins and sat = 1.
- Invalid slots: when out_valid = 0, the X/Y outputs hold their last value and never set sat.
- busy = OR of the four pipeline valid bits.
- W = −1 is representable (tw = −2^(TW_W−1)). W = +1 is approximated by 2^(TW_W−1)−1.
- No assertions are placed on operand ranges. Every input combination produces a defined, saturated result.

Test Plan:
- Reset then single butterfly, a=(1000,0), b=(500,0), tw=(32767,0), scale=0 -> out_valid exactly 4 cycles after in_valid; x=(1000+500=1500,0), y=(500,0); sat=0; busy high for 4 cycles.
- Same operands with scale=1 -> x=(750,0), y=(250,0).
- Twiddle −j, a=(0,0), b=(100,200), tw=(0,−32768) -> t=(200,−100); x=(200,−100), y=(−200,100).
- Overflow, a=(32767,0), b=(32767,0), tw=(32767,0), scale=0 -> x=(32767,0) clipped, y=(1,0); sat=1 and stays 1 afterwards; sat_clr pulse -> sat=0 next cycle; sat_clr coincident with a new clip -> sat stays 1.
- Back-to-back stream of 8 butterflies with random operands against a reference model -> 8 consecutive out_valid cycles in input order, bit-exact results.
- Reset mid-stream: assert rst_n=0 for one cycle while 3 butterflies are in flight -> out_valid, busy and sat are 0 the next cycle; no stale outputs emerge; a fresh butterfly afterwards still has 4-cycle latency.
